mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 23 ++
 rtl/mem_arb_sel.sv | 32 +++
 rtl/mem_arbiter.sv | 143 ++++++++++++++
 tb/tb_mem_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory arbiter.
package mem_arb_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned MASKW = 8;

    // Bit positions inside the one-hot grant vector
    localparam int unsigned GNT_IFU = 0;
    localparam int unsigned GNT_LSU = 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACCESS,
        ST_RESP
    } state_e;

    typedef enum logic {
        OWN_IFU,
        OWN_LSU
    } owner_e;

endpackage

// File: rtl/mem_arb_sel.sv
// Requester selection: one-hot grant from the two request valids.
// MEM_ARB_ROUND_ROBIN_EN selects round-robin on collision; otherwise LSU wins.
module mem_arb_sel
    import mem_arb_pkg::*;
(
    input  logic       ifu_valid,
    input  logic       lsu_valid,
    input  owner_e     ptr,
    output logic [1:0] grant
);

    always_comb begin
        grant = '0;
        if (ifu_valid && lsu_valid) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            grant[GNT_IFU] = (ptr == OWN_IFU);
            grant[GNT_LSU] = (ptr == OWN_LSU);
`else
            grant[GNT_LSU] = 1'b1;
`endif
        end else begin
            grant[GNT_IFU] = ifu_valid;
            grant[GNT_LSU] = lsu_valid;
        end
    end

`ifndef MEM_ARB_ROUND_ROBIN_EN
    logic unused_ptr;
    assign unused_ptr = ptr;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates IFU fetches and LSU loads/stores onto a single DPI memory port.
// Build option: MEM_ARB_ROUND_ROBIN_EN (see mem_arb_sel).
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned LAT = 2
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             ifu_req_valid,
    output logic             ifu_req_ready,
    input  logic [XLEN-1:0]  ifu_addr,
    output logic             ifu_resp_valid,
    input  logic             ifu_resp_ready,
    output logic [XLEN-1:0]  ifu_rdata,

    input  logic             lsu_req_valid,
    output logic             lsu_req_ready,
    input  logic             lsu_wen,
    input  logic [XLEN-1:0]  lsu_addr,
    input  logic [XLEN-1:0]  lsu_wdata,
    input  logic [MASKW-1:0] lsu_wmask,
    output logic             lsu_resp_valid,
    input  logic             lsu_resp_ready,
    output logic [XLEN-1:0]  lsu_rdata,

    output logic             mem_valid,
    output logic             mem_wen,
    output logic [XLEN-1:0]  mem_raddr,
    output logic [XLEN-1:0]  mem_waddr,
    output logic [XLEN-1:0]  mem_wdata,
    output logic [MASKW-1:0] mem_wmask,
    input  logic [XLEN-1:0]  mem_rdata
);

    localparam logic [3:0] LAT_LAST = 4'(LAT - 1);

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    owner_e           owner_q, owner_d;
    owner_e           ptr_q, ptr_d;
    logic             wen_q, wen_d;
    logic [XLEN-1:0]  addr_q, addr_d;
    logic [XLEN-1:0]  wdata_q, wdata_d;
    logic [MASKW-1:0] wmask_q, wmask_d;
    logic [XLEN-1:0]  rdata_q, rdata_d;

    logic [1:0] grant;
    logic       idle;
    logic       resp_fire;

    mem_arb_sel u_sel (
        .ifu_valid (ifu_req_valid),
        .lsu_valid (lsu_req_valid),
        .ptr       (ptr_q),
        .grant     (grant)
    );

    assign idle      = (state_q == ST_IDLE);
    assign resp_fire = (state_q == ST_RESP) &&
                       ((owner_q == OWN_IFU) ? ifu_resp_ready : lsu_resp_ready);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        wen_d   = wen_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (grant != 2'b00) begin
                    owner_d = grant[GNT_LSU] ? OWN_LSU : OWN_IFU;
                    addr_d  = grant[GNT_LSU] ? lsu_addr : ifu_addr;
                    wen_d   = grant[GNT_LSU] & lsu_wen;
                    wdata_d = grant[GNT_LSU] ? lsu_wdata : '0;
                    wmask_d = grant[GNT_LSU] ? lsu_wmask : '0;
                    cnt_d   = '0;
                    state_d = (LAT == 0) ? ST_ACCESS : ST_WAIT;
                    // Pointer only moves on contention, favouring the loser
                    if (ifu_req_valid && lsu_req_valid)
                        ptr_d = grant[GNT_LSU] ? OWN_IFU : OWN_LSU;
                end
            end
            ST_WAIT: begin
                if (cnt_q == LAT_LAST) state_d = ST_ACCESS;
                else                   cnt_d   = cnt_q + 4'd1;
            end
            ST_ACCESS: begin
                rdata_d = wen_q ? '0 : mem_rdata;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (resp_fire) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            owner_q <= OWN_IFU;
            ptr_q   <= OWN_IFU;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            wen_q   <= wen_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            rdata_q <= rdata_d;
        end
    end

    assign ifu_req_ready  = idle & grant[GNT_IFU];
    assign lsu_req_ready  = idle & grant[GNT_LSU];
    assign ifu_resp_valid = (state_q == ST_RESP) && (owner_q == OWN_IFU);
    assign lsu_resp_valid = (state_q == ST_RESP) && (owner_q == OWN_LSU);
    assign ifu_rdata      = rdata_q;
    assign lsu_rdata      = rdata_q;

    // Address/data stay on their latched values; only the strobes are gated
    assign mem_valid = (state_q == ST_ACCESS);
    assign mem_wen   = (state_q == ST_ACCESS) & wen_q;
    assign mem_raddr = addr_q;
    assign mem_waddr = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_wmask = wmask_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table plus scoreboard monitor,
// with hand sequences for collisions, response stall, reset and LAT=0.
module tb_mem_arbiter;

    localparam int unsigned LAT = 2;

    typedef struct {
        bit          lsu;
        bit          wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [7:0]  wmask;
        logic [31:0] exp_rdata;
    } req_t;

    typedef struct {
        bit          lsu;
        bit          wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [7:0]  wmask;
        int          t;
    } mexp_t;

    typedef struct {
        bit          lsu;
        logic [31:0] rdata;
        int          t;
    } rexp_t;

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        return (a == 32'h8000_0000) ? 32'h0000_0413 : (a ^ 32'h3C3C_A5A5);
    endfunction

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready;
    logic [31:0] ifu_addr, ifu_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_resp_ready;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [7:0]  lsu_wmask;
    logic        mem_valid, mem_wen;
    logic [31:0] mem_raddr, mem_waddr, mem_wdata, mem_rdata;
    logic [7:0]  mem_wmask;

    logic        z_ifu_req_valid, z_ifu_req_ready, z_ifu_resp_valid, z_ifu_resp_ready;
    logic [31:0] z_ifu_addr, z_ifu_rdata;
    logic        z_lsu_req_valid, z_lsu_req_ready, z_lsu_wen, z_lsu_resp_valid, z_lsu_resp_ready;
    logic [31:0] z_lsu_addr, z_lsu_wdata, z_lsu_rdata;
    logic [7:0]  z_lsu_wmask;
    logic        z_mem_valid, z_mem_wen;
    logic [31:0] z_mem_raddr, z_mem_waddr, z_mem_wdata, z_mem_rdata;
    logic [7:0]  z_mem_wmask;

    assign mem_rdata   = mem_model(mem_raddr);
    assign z_mem_rdata = mem_model(z_mem_raddr);

    mem_arbiter #(.LAT(LAT)) dut (
        .clk(clk), .reset(reset),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready), .ifu_rdata(ifu_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_wen(lsu_wen),
        .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready), .lsu_rdata(lsu_rdata),
        .mem_valid(mem_valid), .mem_wen(mem_wen), .mem_raddr(mem_raddr), .mem_waddr(mem_waddr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rdata(mem_rdata)
    );

    mem_arbiter #(.LAT(0)) dut0 (
        .clk(clk), .reset(reset),
        .ifu_req_valid(z_ifu_req_valid), .ifu_req_ready(z_ifu_req_ready), .ifu_addr(z_ifu_addr),
        .ifu_resp_valid(z_ifu_resp_valid), .ifu_resp_ready(z_ifu_resp_ready), .ifu_rdata(z_ifu_rdata),
        .lsu_req_valid(z_lsu_req_valid), .lsu_req_ready(z_lsu_req_ready), .lsu_wen(z_lsu_wen),
        .lsu_addr(z_lsu_addr), .lsu_wdata(z_lsu_wdata), .lsu_wmask(z_lsu_wmask),
        .lsu_resp_valid(z_lsu_resp_valid), .lsu_resp_ready(z_lsu_resp_ready), .lsu_rdata(z_lsu_rdata),
        .mem_valid(z_mem_valid), .mem_wen(z_mem_wen), .mem_raddr(z_mem_raddr), .mem_waddr(z_mem_waddr),
        .mem_wdata(z_mem_wdata), .mem_wmask(z_mem_wmask), .mem_rdata(z_mem_rdata)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    mexp_t mq[$];
    rexp_t rq[$];
    req_t  vec[6];
    bit    tb_ptr_lsu = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%08h required=%08h", name, act, exp);
        end
    endtask

    // Scoreboard monitor for the LAT=2 instance
    bit prev_rv = 1'b0;
    always @(negedge clk) begin : monitor
        mexp_t m;
        rexp_t r;
        logic  rv;
        if (reset) begin
            prev_rv = 1'b0;
        end else begin
            rv = ifu_resp_valid | lsu_resp_valid;
            if (mem_valid) begin
                if (mq.size() == 0) chk("mem_spurious", 1, 0);
                else begin
                    m = mq.pop_front();
                    chk("mem_cycle", cyc, m.t);
                    chk("mem_wen", mem_wen, m.wen);
                    chk("mem_raddr", mem_raddr, m.addr);
                    chk("mem_waddr", mem_waddr, m.addr);
                    if (m.lsu) begin
                        chk("mem_wdata", mem_wdata, m.wdata);
                        chk("mem_wmask", mem_wmask, m.wmask);
                    end
                end
            end else if (mem_wen) begin
                chk("mem_wen_outside_access", mem_wen, 0);
            end
            if (ifu_resp_valid && lsu_resp_valid) begin
                chk("resp_both_valid", 1, 0);
            end else if (rv) begin
                if (rq.size() == 0) chk("resp_spurious", 1, 0);
                else begin
                    r = rq[0];
                    chk("resp_owner", lsu_resp_valid, r.lsu);
                    chk("resp_rdata", r.lsu ? lsu_rdata : ifu_rdata, r.rdata);
                    if (!prev_rv) chk("resp_cycle", cyc, r.t);
                    if (r.lsu ? lsu_resp_ready : ifu_resp_ready) void'(rq.pop_front());
                end
            end
            if (rv || mem_valid) chk("ready_while_busy", {ifu_req_ready, lsu_req_ready}, 0);
            prev_rv = rv;
        end
    end

    task automatic drive_req(input req_t r);
        if (r.lsu) begin
            lsu_req_valid = 1'b1; lsu_wen = r.wen; lsu_addr = r.addr;
            lsu_wdata = r.wdata; lsu_wmask = r.wmask;
        end else begin
            ifu_req_valid = 1'b1; ifu_addr = r.addr;
        end
    endtask

    // Called at the negedge where the handshake is visible
    task automatic accept_now(input req_t r);
        int t0;
        t0 = cyc;
        mq.push_back('{r.lsu, r.lsu & r.wen, r.addr, r.wdata, r.wmask, t0 + 1 + int'(LAT)});
        rq.push_back('{r.lsu, r.exp_rdata, t0 + 2 + int'(LAT)});
        @(posedge clk); #1;
        if (r.lsu) lsu_req_valid = 1'b0; else ifu_req_valid = 1'b0;
    endtask

    task automatic wait_accept(input req_t r);
        bit got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (r.lsu ? lsu_req_ready : ifu_req_ready) begin got = 1'b1; break; end
        end
        chk("accept", got, 1);
        if (got) accept_now(r);
        else begin
            @(posedge clk); #1;
            if (r.lsu) lsu_req_valid = 1'b0; else ifu_req_valid = 1'b0;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (mq.size() == 0 && rq.size() == 0) break;
        end
        chk("drain_mem", mq.size(), 0);
        chk("drain_resp", rq.size(), 0);
        mq.delete();
        rq.delete();
    endtask

    task automatic collide(input req_t ri, input req_t rl, input bit exp_lsu_first);
        bit got = 1'b0;
        @(posedge clk); #1;
        drive_req(ri);
        drive_req(rl);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ifu_req_ready || lsu_req_ready) begin got = 1'b1; break; end
        end
        chk("collide_accept", got, 1);
        if (got) begin
            chk("collide_onehot", ifu_req_ready & lsu_req_ready, 0);
            chk("collide_winner_lsu", lsu_req_ready, exp_lsu_first);
            if (lsu_req_ready) begin accept_now(rl); wait_accept(ri); end
            else               begin accept_now(ri); wait_accept(rl); end
        end else begin
            @(posedge clk); #1;
            ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        end
        drain();
    endtask

    task automatic z_txn(input req_t r);
        @(posedge clk); #1;
        if (r.lsu) begin
            z_lsu_req_valid = 1'b1; z_lsu_wen = r.wen; z_lsu_addr = r.addr;
            z_lsu_wdata = r.wdata; z_lsu_wmask = r.wmask;
        end else begin
            z_ifu_req_valid = 1'b1; z_ifu_addr = r.addr;
        end
        @(negedge clk);
        chk("z_req_ready", r.lsu ? z_lsu_req_ready : z_ifu_req_ready, 1);
        @(posedge clk); #1;
        z_ifu_req_valid = 1'b0; z_lsu_req_valid = 1'b0;
        @(negedge clk);
        chk("z_mem_valid_t1", z_mem_valid, 1);
        chk("z_mem_wen_t1", z_mem_wen, r.lsu & r.wen);
        chk("z_mem_raddr_t1", z_mem_raddr, r.addr);
        chk("z_resp_valid_t1", z_ifu_resp_valid | z_lsu_resp_valid, 0);
        @(negedge clk);
        chk("z_mem_valid_t2", z_mem_valid, 0);
        chk("z_resp_valid_t2", r.lsu ? z_lsu_resp_valid : z_ifu_resp_valid, 1);
        chk("z_rdata_t2", r.lsu ? z_lsu_rdata : z_ifu_rdata, r.exp_rdata);
        @(negedge clk);
        chk("z_resp_valid_t3", z_ifu_resp_valid | z_lsu_resp_valid, 0);
    endtask

    initial begin
        bit exp_lsu;
        bit seen;
        vec[0] = '{1'b0, 1'b0, 32'h8000_0000, 32'h0, 8'h00, 32'h0000_0413};
        vec[1] = '{1'b1, 1'b1, 32'h8000_1000, 32'hDEAD_BEEF, 8'h0F, 32'h0};
        vec[2] = '{1'b1, 1'b0, 32'h8000_1000, 32'h0, 8'h00, mem_model(32'h8000_1000)};
        vec[3] = '{1'b0, 1'b0, 32'h8000_0004, 32'h0, 8'h00, mem_model(32'h8000_0004)};
        vec[4] = '{1'b1, 1'b1, 32'h0000_0010, 32'h1234_5678, 8'hFF, 32'h0};
        vec[5] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0, 8'h00, mem_model(32'hFFFF_FFFC)};

        reset = 1'b1;
        ifu_req_valid = 1'b0; ifu_addr = '0; ifu_resp_ready = 1'b1;
        lsu_req_valid = 1'b0; lsu_wen = 1'b0; lsu_addr = '0; lsu_wdata = '0;
        lsu_wmask = '0; lsu_resp_ready = 1'b1;
        z_ifu_req_valid = 1'b0; z_ifu_addr = '0; z_ifu_resp_ready = 1'b1;
        z_lsu_req_valid = 1'b0; z_lsu_wen = 1'b0; z_lsu_addr = '0; z_lsu_wdata = '0;
        z_lsu_wmask = '0; z_lsu_resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {ifu_req_ready, lsu_req_ready}, 0);
        chk("rst_resp_valid", {ifu_resp_valid, lsu_resp_valid}, 0);
        chk("rst_ifu_rdata", ifu_rdata, 0);
        chk("rst_lsu_rdata", lsu_rdata, 0);
        chk("rst_mem_strobes", {mem_valid, mem_wen}, 0);
        chk("rst_mem_raddr", mem_raddr, 0);
        chk("rst_mem_waddr", mem_waddr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_mem_wmask", mem_wmask, 0);
        chk("rst_z_mem_valid", z_mem_valid, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        foreach (vec[i]) begin
            @(posedge clk); #1;
            drive_req(vec[i]);
            wait_accept(vec[i]);
            drain();
        end

        for (int k = 0; k < 2; k++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            exp_lsu = tb_ptr_lsu;
            tb_ptr_lsu = !exp_lsu;
`else
            exp_lsu = 1'b1;
`endif
            collide(vec[k == 0 ? 0 : 3], vec[k == 0 ? 1 : 2], exp_lsu);
        end

        // Response stall with a competing LSU request pending
        ifu_resp_ready = 1'b0;
        @(posedge clk); #1;
        drive_req(vec[3]);
        wait_accept(vec[3]);
        drive_req(vec[4]);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ifu_resp_valid) begin seen = 1'b1; break; end
        end
        chk("stall_resp_seen", seen, 1);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            chk("stall_resp_valid", ifu_resp_valid, 1);
            chk("stall_rdata", ifu_rdata, vec[3].exp_rdata);
            chk("stall_req_ready", {ifu_req_ready, lsu_req_ready}, 0);
        end
        @(posedge clk); #1;
        ifu_resp_ready = 1'b1;
        wait_accept(vec[4]);
        drain();

        // Reset while in WAIT abandons the transaction
        @(posedge clk); #1;
        drive_req(vec[0]);
        wait_accept(vec[0]);
        reset = 1'b1;
        mq.delete();
        rq.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < int'(LAT) + 4; i++) begin
            @(negedge clk);
            chk("rstwait_mem_valid", mem_valid, 0);
            chk("rstwait_resp_valid", {ifu_resp_valid, lsu_resp_valid}, 0);
        end
        @(posedge clk); #1;
        drive_req(vec[2]);
        wait_accept(vec[2]);
        drain();

        z_txn(vec[0]);
        z_txn(vec[1]);
        z_txn(vec[5]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=%0d required=finished", cyc);
        $fatal(1);
    end

endmodule
